alu_arbiter: RTL and testbench

- Shares one 32-bit `ALU` instance between `NREQ` requesters, for example the main execute stage and an address/branch helper unit.
- Each requester issues operations on a valid/ready request channel and gets its registered result back on its own valid/ready response channel.
- Grant is round-robin; one operation is in flight at a time.
- Sits between the requesting units and the `ALU` instance it owns.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu.sv | 34 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode and arbiter FSM definitions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_e;

    // Highest legal opcode; anything above it is flagged as an error response.
    localparam logic [3:0] ALU_OP_MAX = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU: add/sub, logic ops, shifts by B[4:0], signed/unsigned compare.
// Latency: purely combinational, zero cycles.
// Backpressure: none; undefined opcodes produce Result 0 and Zero 1.
module ALU
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALUOp,
    output logic [31:0] Result,
    output logic        Zero
);

    // Opcode decode; results wrap at 32 bits.
    always_comb begin
        Result = '0;
        case (ALUOp)
            OP_ADD:  Result = A + B;
            OP_SUB:  Result = A - B;
            OP_AND:  Result = A & B;
            OP_OR:   Result = A | B;
            OP_XOR:  Result = A ^ B;
            OP_SLL:  Result = A << B[4:0];
            OP_SRL:  Result = A >> B[4:0];
            OP_SRA:  Result = $unsigned($signed(A) >>> B[4:0]);
            OP_SLT:  Result = {31'b0, ($signed(A) < $signed(B))};
            OP_SLTU: Result = {31'b0, (A < B)};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == 32'd0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester after ptr (wrapping) with req high wins.
// Latency: combinational, zero cycles.
// Backpressure: none; gnt is all-zero and gnt_vld low when nobody requests.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    int cand;

    // Scan ptr+1, ptr+2, ... modulo NREQ and keep the first hit.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = IW'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters, round-robin, one op in flight; ALU_ARB_STATS_EN adds grant/stall counters.
// Latency: accept in cycle N, registered result with resp_valid from N+1.
// Backpressure: result held until owner's resp_ready; a new accept may coincide with that handshake.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_A,
    input  logic [NREQ-1:0][31:0] req_B,
    input  logic [NREQ-1:0][3:0]  req_ALUOp,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [31:0]           resp_Result,
    output logic                  resp_Zero,
    output logic                  resp_err
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][15:0] grant_cnt,
    output logic [NREQ-1:0][15:0] stall_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   owner;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic            hs;
    logic            accept_en;
    logic            accept;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [3:0]      alu_op;
    logic [31:0]     alu_result;
    logic            alu_zero;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (last_grant),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Handshake/accept decode; depends only on valids, state and the owner's resp_ready.
    always_comb begin
        hs        = (state == HOLD) && resp_ready[owner];
        accept_en = (state == IDLE) || hs;
        accept    = accept_en && gnt_vld;
        req_ready = accept ? gnt : '0;
    end

    // Winner's operands feed the shared ALU directly; no extra pipeline stage.
    always_comb begin
        alu_a  = req_A[gnt_idx];
        alu_b  = req_B[gnt_idx];
        alu_op = req_ALUOp[gnt_idx];
    end

    ALU u_alu (
        .A      (alu_a),
        .B      (alu_b),
        .ALUOp  (alu_op),
        .Result (alu_result),
        .Zero   (alu_zero)
    );

    // IDLE/HOLD FSM with registered response; reset discards any pending result at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= IW'(NREQ - 1);
            owner       <= '0;
            resp_valid  <= '0;
            resp_Result <= '0;
            resp_Zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else if (accept) begin
            state       <= HOLD;
            owner       <= gnt_idx;
            last_grant  <= gnt_idx;
            resp_valid  <= gnt;
            resp_Result <= alu_result;
            resp_Zero   <= alu_zero;
            resp_err    <= (alu_op > ALU_OP_MAX);
        end else if (hs) begin
            state      <= IDLE;
            resp_valid <= '0;
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester saturating grant and stall counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && (grant_cnt[i] != 16'hFFFF))
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                if (req_valid[i] && !req_ready[i] && (stall_cnt[i] != 16'hFFFF))
                    stall_cnt[i] <= stall_cnt[i] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with NREQ=2: reference model plus result scoreboard.
// Latency: checks results one cycle after accept.
// Backpressure: exercises stalled responses and back-to-back accepts.
module tb_alu_arbiter;

    localparam int NREQ = 2;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        e;
    } exp_t;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_A;
    logic [NREQ-1:0][31:0] req_B;
    logic [NREQ-1:0][3:0]  req_ALUOp;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [31:0]           resp_Result;
    logic                  resp_Zero;
    logic                  resp_err;
`ifdef ALU_ARB_STATS_EN
    logic [NREQ-1:0][15:0] grant_cnt;
    logic [NREQ-1:0][15:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    exp_t sb_q[$];
    bit   m_hold;
    int   m_owner;
    int   m_last;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_A       (req_A),
        .req_B       (req_B),
        .req_ALUOp   (req_ALUOp),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_Result (resp_Result),
        .resp_Zero   (resp_Zero),
        .resp_err    (resp_err)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt   (grant_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        x.e = 1'b0;
        case (op)
            4'd0: x.r = a + b;
            4'd1: x.r = a - b;
            4'd2: x.r = a & b;
            4'd3: x.r = a | b;
            4'd4: x.r = a ^ b;
            4'd5: x.r = a << b[4:0];
            4'd6: x.r = a >> b[4:0];
            4'd7: x.r = $unsigned($signed(a) >>> b[4:0]);
            4'd8: x.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: x.r = (a < b) ? 32'd1 : 32'd0;
            default: begin
                x.r = 32'd0;
                x.e = 1'b1;
            end
        endcase
        x.z = (x.r == 32'd0);
        return x;
    endfunction

    // Reference model: tracks hold/owner/pointer, predicts req_ready and resp_valid, scoreboards results.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_result", resp_Result, 0);
            check("rst_zero", resp_Zero, 0);
            check("rst_err", resp_err, 0);
            sb_q.delete();
            m_hold = 1'b0;
            m_owner = 0;
            m_last = NREQ - 1;
        end else begin
            bit hs, en;
            int win;
            logic [NREQ-1:0] exp_rv, exp_rr;
            exp_rv = m_hold ? NREQ'(1 << m_owner) : '0;
            check("resp_valid", resp_valid, exp_rv);
            if (m_hold) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 0, 1);
                end else begin
                    check("resp_result", resp_Result, sb_q[0].r);
                    check("resp_zero", resp_Zero, sb_q[0].z);
                    check("resp_err", resp_err, sb_q[0].e);
                end
            end
            hs = m_hold && resp_ready[m_owner];
            if (hs && sb_q.size() > 0) void'(sb_q.pop_front());
            en = !m_hold || hs;
            win = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (win < 0 && req_valid[c]) win = c;
            end
            exp_rr = (en && win >= 0) ? NREQ'(1 << win) : '0;
            check("req_ready", req_ready, exp_rr);
            if (en && win >= 0) begin
                sb_q.push_back(model(req_ALUOp[win], req_A[win], req_B[win]));
                m_hold = 1'b1;
                m_owner = win;
                m_last = win;
            end else if (hs) begin
                m_hold = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        req_valid = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_ALUOp[i] = op;
        req_A[i] = a;
        req_B[i] = b;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_A = '0;
        req_B = '0;
        req_ALUOp = '0;
        resp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single ADD after reset
        set_req(0, 4'd0, 32'd5, 32'd7);
        resp_ready = 2'b11;
        req_valid = 2'b01;
        @(negedge clk);
        check("t1_req_ready", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("t1_resp_valid", resp_valid, 2'b01);
        check("t1_result", resp_Result, 32'd12);
        check("t1_zero", resp_Zero, 0);
        repeat (2) @(posedge clk);

        // Contention: grants must alternate starting with requester 0
        do_reset();
        set_req(0, 4'd1, 32'd3, 32'd3);
        set_req(1, 4'd4, 32'hF0, 32'h0F);
        resp_ready = 2'b11;
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("cont_gnt", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) begin
                check("cont_result", resp_Result, (i % 2 == 1) ? 32'd0 : 32'hFF);
                check("cont_zero", resp_Zero, (i % 2 == 1) ? 1 : 0);
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);

        // Backpressure on requester 1 with SRA, requester 0 waiting behind it
        #1;
        set_req(1, 4'd7, 32'h80000000, 32'd4);
        set_req(0, 4'd0, 32'd1, 32'd2);
        resp_ready = 2'b01;
        req_valid = 2'b10;
        @(negedge clk);
        check("bp_accept", req_ready, 2'b10);
        @(posedge clk);
        #1;
        req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stall_ready", req_ready, 0);
            check("bp_stall_result", resp_Result, 32'hF8000000);
            check("bp_stall_valid", resp_valid, 2'b10);
            if (i < 4) @(posedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready = 2'b11;
        @(negedge clk);
        check("bp_b2b_accept", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("bp_next_result", resp_Result, 32'd3);
        repeat (2) @(posedge clk);

        // Illegal opcode
        #1;
        set_req(0, 4'hC, 32'd1, 32'd1);
        req_valid = 2'b01;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("ill_err", resp_err, 1);
        check("ill_result", resp_Result, 0);
        check("ill_zero", resp_Zero, 1);
        repeat (2) @(posedge clk);

        // Reset asserted while requester 0 holds a result
        #1;
        set_req(0, 4'd0, 32'd2, 32'd3);
        resp_ready = 2'b10;
        req_valid = 2'b01;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("mid_hold_valid", resp_valid, 2'b01);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_result", resp_Result, 0);
        check("mid_rst_zero", resp_Zero, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        resp_ready = 2'b11;
        set_req(1, 4'd8, 32'hFFFFFFFF, 32'd1);
        req_valid = 2'b11;
        @(negedge clk);
        check("post_rst_gnt", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);

`ifdef ALU_ARB_STATS_EN
        // Statistics over ten contended cycles
        do_reset();
        set_req(0, 4'd1, 32'd3, 32'd3);
        set_req(1, 4'd4, 32'hF0, 32'h0F);
        resp_ready = 2'b11;
        req_valid = 2'b11;
        repeat (10) @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("stat_grant0", grant_cnt[0], 16'd5);
        check("stat_grant1", grant_cnt[1], 16'd5);
        check("stat_stall_nz", (stall_cnt[0] != 0) || (stall_cnt[1] != 0), 1);
        repeat (3) @(posedge clk);
`endif

        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
